// File: rtl/reg_share_arbiter.sv
// Round-robin arbiter that lets NREQ requesters take turns writing one shared register.
// A transaction is IDLE -> GRANT -> DONE; only the granted requester may write, and only once.
module reg_share_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_i,
    input  logic [NREQ*WIDTH-1:0] wdata_i,
    input  logic                  clr_i,
    output logic [NREQ-1:0]       gnt_o,
    output logic [NREQ-1:0]       ack_o,
    output logic [WIDTH-1:0]      q_o,
    output logic [IDXW-1:0]       owner_o,
    output logic                  valid_o,
    output logic                  busy_o
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        DONE
    } state_e;

    state_e            state_q, state_d;
    logic [IDXW-1:0]   ptr_q, ptr_d;
    logic [IDXW-1:0]   win_q, win_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic [IDXW-1:0]   owner_q, owner_d;
    logic              valid_q, valid_d;

    logic [WIDTH-1:0]  slices [NREQ];
    logic [IDXW-1:0]   winIdx;
    logic [IDXW-1:0]   nextPtr;
    logic              anyReq;
    logic              writeEn;

    for (genvar i = 0; i < NREQ; i++) begin : gSlice
        assign slices[i] = wdata_i[i*WIDTH +: WIDTH];
    end

    assign anyReq  = |req_i;
    assign writeEn = (state_q == GRANT) && !clr_i && req_i[win_q];
    assign nextPtr = (win_q == IDXW'(NREQ - 1)) ? '0 : win_q + 1'b1;

    // First set request bit at or above ptr, wrapping past NREQ-1 back to 0.
    always_comb begin
        logic [IDXW:0] cand;
        winIdx = '0;
        cand   = '0;
        for (int off = NREQ - 1; off >= 0; off--) begin
            cand = {1'b0, ptr_q} + (IDXW+1)'(off);
            if (cand >= (IDXW+1)'(NREQ)) begin
                cand = cand - (IDXW+1)'(NREQ);
            end
            if (req_i[cand[IDXW-1:0]]) begin
                winIdx = cand[IDXW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            gnt_q   <= '0;
            ack_q   <= '0;
            data_q  <= '0;
            owner_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            data_q  <= data_d;
            owner_q <= owner_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (anyReq) state_d = GRANT;
            GRANT:   state_d = writeEn ? DONE : IDLE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A clear in GRANT both blocks the write (writeEn) and zeroes the register.
    always_comb begin
        ptr_d   = ptr_q;
        win_d   = win_q;
        gnt_d   = '0;
        ack_d   = '0;
        data_d  = data_q;
        owner_d = owner_q;
        valid_d = valid_q;
        busy_o  = (state_q != IDLE);
        if (state_q == IDLE && anyReq) begin
            win_d         = winIdx;
            gnt_d[winIdx] = 1'b1;
        end
        if (writeEn) begin
            data_d       = slices[win_q];
            owner_d      = win_q;
            valid_d      = 1'b1;
            ack_d[win_q] = 1'b1;
            ptr_d        = nextPtr;
        end
        if (clr_i) begin
            data_d  = '0;
            valid_d = 1'b0;
        end
    end

    assign gnt_o   = gnt_q;
    assign ack_o   = ack_q;
    assign q_o     = data_q;
    assign owner_o = owner_q;
    assign valid_o = valid_q;

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Bench for reg_share_arbiter: directed scenarios plus random traffic, all compared
// against a transaction-level model of the round-robin shared-register protocol.
module tb_reg_share_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] wdata;
    logic        clr;
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic [7:0]  q;
    logic [1:0]  owner;
    logic        valid;
    logic        busy;

    int total = 0;
    int bad   = 0;

    // Model: phase 0 = waiting, 1 = winner holds the grant, 2 = winner is being acked.
    int         mPhase;
    int         mWin;
    int         mPtr;
    logic [7:0] mQ;
    int         mOwner;
    bit         mValid;

    reg_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_i   (req),
        .wdata_i (wdata),
        .clr_i   (clr),
        .gnt_o   (gnt),
        .ack_o   (ack),
        .q_o     (q),
        .owner_o (owner),
        .valid_o (valid),
        .busy_o  (busy)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        assert (actual === expected) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    task modelReset();
        mPhase = 0;
        mWin   = 0;
        mPtr   = 0;
        mQ     = '0;
        mOwner = 0;
        mValid = 1'b0;
    endtask

    task modelStep(input logic [3:0] r, input logic [31:0] wd, input logic c);
        int phaseNow;
        phaseNow = mPhase;
        if (phaseNow == 0) begin
            for (int k = 0; k < NREQ; k++) begin
                int idx;
                idx = (mPtr + k) % NREQ;
                if (r[idx]) begin
                    mWin   = idx;
                    mPhase = 1;
                    break;
                end
            end
        end else if (phaseNow == 1) begin
            if (!c && r[mWin]) begin
                mQ     = wd[mWin*WIDTH +: WIDTH];
                mOwner = mWin;
                mValid = 1'b1;
                mPtr   = (mWin + 1) % NREQ;
                mPhase = 2;
            end else begin
                mPhase = 0;
            end
        end else begin
            mPhase = 0;
        end
        if (c) begin
            mQ     = '0;
            mValid = 1'b0;
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [3:0] expGnt;
        logic [3:0] expAck;
        expGnt = (mPhase == 1) ? 4'(1 << mWin) : 4'd0;
        expAck = (mPhase == 2) ? 4'(1 << mWin) : 4'd0;
        checkVal({tag, ".gnt"},   32'(gnt),   32'(expGnt));
        checkVal({tag, ".ack"},   32'(ack),   32'(expAck));
        checkVal({tag, ".q"},     32'(q),     32'(mQ));
        checkVal({tag, ".owner"}, 32'(owner), 32'(mOwner));
        checkVal({tag, ".valid"}, 32'(valid), 32'(mValid));
        checkVal({tag, ".busy"},  32'(busy),  32'(mPhase != 0));
    endtask

    task applyStimulus(input logic [3:0] r, input logic [31:0] wd, input logic c, input string tag);
        req   = r;
        wdata = wd;
        clr   = c;
        @(posedge clk);
        modelStep(r, wd, c);
        #1;
        checkOutput(tag);
    endtask

    task doReset();
        rst_n = 1'b0;
        req   = '0;
        wdata = '0;
        clr   = 1'b0;
        modelReset();
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("reset");
        rst_n = 1'b1;
    endtask

    task idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(4'd0, 32'd0, 1'b0, "idle");
    endtask

    function automatic int oneHotIdx(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v == 4'(1 << i)) return i;
        return -1;
    endfunction

    initial begin
        int         order [$];
        int         when  [$];
        int         expOrder [5];
        logic [7:0] qHold;

        $display("[TB] start");
        doReset();

        // Single request from requester 0.
        applyStimulus(4'b0001, 32'h0000_00A5, 1'b0, "single.N1");
        checkVal("single.gntN1", 32'(gnt), 32'h1);
        applyStimulus(4'b0001, 32'h0000_00A5, 1'b0, "single.N2");
        checkVal("single.qN2", 32'(q), 32'hA5);
        checkVal("single.ackN2", 32'(ack), 32'h1);
        checkVal("single.validN2", 32'(valid), 32'h1);
        applyStimulus(4'b0001, 32'h0000_00A5, 1'b0, "single.N3");
        checkVal("single.busyN3", 32'(busy), 32'h0);
        idleCycles(1);

        // Round robin with every requester asserting.
        doReset();
        expOrder = '{0, 1, 2, 3, 0};
        for (int cyc = 0; cyc < 15; cyc++) begin
            applyStimulus(4'b1111, $urandom, 1'b0, "rr");
            if (gnt != 4'd0) begin
                order.push_back(oneHotIdx(gnt));
                when.push_back(cyc);
            end
        end
        checkVal("rr.count", 32'(order.size()), 32'd5);
        for (int i = 0; i < order.size() && i < 5; i++) begin
            checkVal("rr.order", 32'(order[i]), 32'(expOrder[i]));
            if (i > 0) checkVal("rr.spacing", 32'(when[i] - when[i-1]), 32'd3);
        end
        idleCycles(2);

        // Requester 2 writes, moving the pointer to 3; 0 must then beat 2.
        applyStimulus(4'b0100, 32'h0033_0000, 1'b0, "ptr.w2");
        applyStimulus(4'b0100, 32'h0033_0000, 1'b0, "ptr.w2");
        applyStimulus(4'b0100, 32'h0033_0000, 1'b0, "ptr.w2");
        applyStimulus(4'b0101, 32'h0044_0011, 1'b0, "ptr.wrap");
        checkVal("ptr.gnt0", 32'(gnt), 32'h1);
        applyStimulus(4'b0101, 32'h0044_0011, 1'b0, "ptr.wrap");
        checkVal("ptr.q", 32'(q), 32'h11);
        idleCycles(2);

        // Requester 1 withdraws during GRANT, then still has priority.
        qHold = mQ;
        applyStimulus(4'b0010, 32'h0000_7700, 1'b0, "wd.grant");
        checkVal("wd.gnt1", 32'(gnt), 32'h2);
        applyStimulus(4'b0000, 32'h0000_7700, 1'b0, "wd.drop");
        checkVal("wd.qHeld", 32'(q), 32'(qHold));
        checkVal("wd.noAck", 32'(ack), 32'h0);
        applyStimulus(4'b1010, 32'h0000_6600, 1'b0, "wd.rearb");
        checkVal("wd.gnt1Again", 32'(gnt), 32'h2);
        applyStimulus(4'b1010, 32'h0000_6600, 1'b0, "wd.write");
        idleCycles(2);

        // Clear during requester 3's GRANT.
        applyStimulus(4'b1000, 32'h9900_0000, 1'b0, "clr.grant");
        checkVal("clr.gnt3", 32'(gnt), 32'h8);
        applyStimulus(4'b1000, 32'h9900_0000, 1'b1, "clr.hit");
        checkVal("clr.q", 32'(q), 32'h0);
        checkVal("clr.valid", 32'(valid), 32'h0);
        checkVal("clr.noAck", 32'(ack), 32'h0);
        applyStimulus(4'b1100, 32'h0000_0000, 1'b0, "clr.ptr");
        checkVal("clr.ptrKept", 32'(gnt), 32'h4);
        applyStimulus(4'b1100, 32'h0022_0000, 1'b0, "clr.after");
        idleCycles(2);

        // Random traffic against the model.
        for (int i = 0; i < 300; i++) begin
            applyStimulus(4'($urandom_range(0, 15)), $urandom, ($urandom_range(0, 9) == 0), "rand");
        end
        idleCycles(3);

        // Reset asserted mid-cycle while in DONE.
        applyStimulus(4'b0001, 32'h0000_005A, 1'b0, "rst.grant");
        applyStimulus(4'b0001, 32'h0000_005A, 1'b0, "rst.done");
        checkVal("rst.ackBefore", 32'(ack), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput("rst.async");
        checkVal("rst.ackDropped", 32'(ack), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(4'b0010, 32'h0000_0000, 1'b0, "rst.after");
        idleCycles(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
